// File: rtl/weight_normalize.sv
// weight_normalize: divides each sign-magnitude weight by the vector norm,
// one weight at a time through a shared restoring divider, and returns
// Q0.FRAC unit-scaled magnitudes with the sign preserved.
//
// state | meaning
// IDLE  | waiting for a vector; in_ready high
// DIV   | one quotient bit per cycle for weight idx, MSB first
// STORE | saturate quotient and write field idx of the result
// DONE  | result valid; held until out_ready
module weight_normalize #(
   parameter int N_W    = 20,
   parameter int W_W    = 9,
   parameter int NORM_W = 11,
   parameter int FRAC   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_W*W_W-1:0]   weights_in,
   input  logic [NORM_W-1:0]    norm_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N_W*W_W-1:0]   weights_out,
   output logic                 div_zero,
   output logic                 busy
);

   localparam int MAG_W = W_W - 1;
   localparam int DVD_W = MAG_W + FRAC;
   localparam int REM_W = NORM_W + 1;
   localparam int IDX_W = $clog2(N_W);
   localparam int CNT_W = $clog2(DVD_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_W - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DVD_W - 1);
   localparam logic [FRAC-1:0]  Q_MAX    = '1;

   typedef enum logic [1:0] {IDLE, DIV, STORE, DONE} state_t;

   state_t state, state_nxt;

   logic [N_W*W_W-1:0] w_lat;
   logic [NORM_W-1:0]  norm_lat;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   bit_cnt;
   logic [REM_W-1:0]   rem;
   logic [DVD_W-1:0]   quot;

   logic [W_W-1:0]     cur_w;
   logic [DVD_W-1:0]   dvd;
   logic [REM_W-1:0]   rem_sh;
   logic               rem_ge;
   logic [REM_W-1:0]   rem_nx;
   logic [FRAC-1:0]    q_sat;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (in_valid) state_nxt = (norm_in == '0) ? DONE : DIV;
         DIV:   if (bit_cnt == '0) state_nxt = STORE;
         STORE: state_nxt = (idx == IDX_LAST) ? DONE : DIV;
         DONE:  if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // divider step and saturation for the current weight
   always_comb begin
      cur_w  = w_lat[int'(idx)*W_W +: W_W];
      dvd    = {cur_w[MAG_W-1:0], {FRAC{1'b0}}};
      rem_sh = {rem[NORM_W-1:0], dvd[bit_cnt]};
      rem_ge = (rem_sh >= {1'b0, norm_lat});
      rem_nx = rem_ge ? (rem_sh - {1'b0, norm_lat}) : rem_sh;
      q_sat  = (quot > DVD_W'(Q_MAX)) ? Q_MAX : quot[FRAC-1:0];
   end

   // datapath: latch inputs, iterate divider, write result fields
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_lat       <= '0;
         norm_lat    <= '0;
         idx         <= '0;
         bit_cnt     <= '0;
         rem         <= '0;
         quot        <= '0;
         weights_out <= '0;
         div_zero    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  w_lat       <= weights_in;
                  norm_lat    <= norm_in;
                  weights_out <= '0;
                  idx         <= '0;
                  rem         <= '0;
                  quot        <= '0;
                  bit_cnt     <= CNT_LOAD;
                  div_zero    <= (norm_in == '0);
               end
            end
            DIV: begin
               rem  <= rem_nx;
               quot <= {quot[DVD_W-2:0], rem_ge};
               if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
            end
            STORE: begin
               // suppress negative zero when the magnitude rounds to 0
               weights_out[int'(idx)*W_W +: W_W] <= {cur_w[W_W-1] & (q_sat != '0), q_sat};
               if (idx != IDX_LAST) begin
                  idx     <= idx + 1'b1;
                  rem     <= '0;
                  quot    <= '0;
                  bit_cnt <= CNT_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == DIV) || (state == STORE);

endmodule

// File: tb/tb_weight_normalize.sv
// Directed bench for weight_normalize with hand-computed expected results.
module tb_weight_normalize;

   localparam int N_W    = 20;
   localparam int W_W    = 9;
   localparam int NORM_W = 11;
   localparam int VW     = N_W * W_W;
   localparam int LAT    = N_W * 17;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [VW-1:0]     weights_in;
   logic [NORM_W-1:0] norm_in;
   logic              out_valid;
   logic              out_ready;
   logic [VW-1:0]     weights_out;
   logic              div_zero;
   logic              busy;

   int n_vec = 0;
   int n_err = 0;

   weight_normalize dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .weights_in  (weights_in),
      .norm_in     (norm_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .weights_out (weights_out),
      .div_zero    (div_zero),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] fill(input logic [W_W-1:0] v);
      logic [VW-1:0] r;
      for (int k = 0; k < N_W; k++) r[k*W_W +: W_W] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] put(input logic [VW-1:0] base, input int k, input logic [W_W-1:0] v);
      logic [VW-1:0] r;
      r = base;
      r[k*W_W +: W_W] = v;
      return r;
   endfunction

   // present one vector for one cycle, then wait (bounded) for out_valid
   task automatic run_vec(input string tag, input logic [VW-1:0] w, input logic [NORM_W-1:0] n,
                          input int exp_lat);
      int lat;
      in_valid   = 1'b1;
      weights_in = w;
      norm_in    = n;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      weights_in = ~w;
      norm_in    = ~n;
      lat = 0;
      while (!out_valid && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, VW'(lat), VW'(exp_lat));
   endtask

   task automatic accept(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_in_ready_after"}, VW'(in_ready), VW'(1));
      chk({tag, "_out_valid_after"}, VW'(out_valid), VW'(0));
   endtask

   logic [VW-1:0] v2, e2, v3, e3, v3b, e3b, v7, e7;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      weights_in = '0; norm_in = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_in_ready",  VW'(in_ready),  VW'(1));
      chk("rst_out_valid", VW'(out_valid), VW'(0));
      chk("rst_busy",      VW'(busy),      VW'(0));
      chk("rst_div_zero",  VW'(div_zero),  VW'(0));
      chk("rst_weights",   weights_out,    '0);

      // 1) 255/255 saturates to 0xFF
      run_vec("t1", put('0, 0, 9'h0FF), 11'd255, LAT);
      chk("t1_weights",  weights_out,   put('0, 0, 9'h0FF));
      chk("t1_div_zero", VW'(div_zero), VW'(0));
      accept("t1");

      // 2) 100/447 -> 57 everywhere
      v2 = fill(9'h064);
      e2 = fill(9'h039);
      run_vec("t2", v2, 11'd447, LAT);
      chk("t2_weights", weights_out, e2);
      accept("t2");

      // 3) sign handling, and no negative zero
      v3 = put(fill(9'h064), 3, 9'h164);
      e3 = put(fill(9'h039), 3, 9'h139);
      run_vec("t3", v3, 11'd447, LAT);
      chk("t3_weights", weights_out, e3);
      accept("t3");

      v3b = put(put(put('0, 0, 9'h101), 1, 9'h1FF), 2, 9'h100);
      e3b = put('0, 1, 9'h192);
      run_vec("t3b", v3b, 11'd447, LAT);
      chk("t3b_weights", weights_out, e3b);
      accept("t3b");

      // inconsistent norm: saturate, never wrap
      v7 = put(put('0, 0, 9'h0C8), 1, 9'h132);
      e7 = put(put('0, 0, 9'h0FF), 1, 9'h180);
      run_vec("t7", v7, 11'd100, LAT);
      chk("t7_weights", weights_out, e7);
      accept("t7");

      // 4) zero norm
      run_vec("t4", fill(9'h064), 11'd0, 0);
      chk("t4_weights",  weights_out,   '0);
      chk("t4_div_zero", VW'(div_zero), VW'(1));
      accept("t4");

      // 5) back-pressure at DONE, in_valid pulses ignored
      run_vec("t5", v2, 11'd447, LAT);
      for (int i = 0; i < 10; i++) begin
         in_valid   = i[0];
         weights_in = fill(9'h0AA);
         norm_in    = 11'd0;
         @(posedge clk); #1;
         chk("t5_hold_valid",    VW'(out_valid), VW'(1));
         chk("t5_hold_in_ready", VW'(in_ready),  VW'(0));
         chk("t5_hold_weights",  weights_out,    e2);
         chk("t5_hold_div_zero", VW'(div_zero),  VW'(0));
      end
      in_valid = 1'b0;
      accept("t5");
      chk("t5_idle_busy", VW'(busy), VW'(0));

      // 6) reset mid-DIV at idx 7, then a fresh vector completes normally
      in_valid   = 1'b1;
      weights_in = put('0, 0, 9'h0FF);
      norm_in    = 11'd255;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7 * 17 + 5) @(posedge clk);
      #1;
      chk("t6_busy_mid", VW'(busy), VW'(1));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t6_out_valid", VW'(out_valid), VW'(0));
      chk("t6_weights",   weights_out,    '0);
      chk("t6_in_ready",  VW'(in_ready),  VW'(1));
      chk("t6_busy",      VW'(busy),      VW'(0));
      run_vec("t6_new", v2, 11'd447, LAT);
      chk("t6_new_weights", weights_out, e2);
      accept("t6_new");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
